// File: rtl/ifetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_prefetch
// Description : Instruction fetch unit with a DEPTH-entry prefetch queue.
//               Issues one word read per cycle while the queue has room,
//               pushes the response one cycle later, and flushes on redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_prefetch #(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_en,
    output logic [ADDR_W-3:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic [ADDR_W-1:0] out_link
);

    localparam int                c_PTR_W    = $clog2(DEPTH);
    localparam int                c_CNT_W    = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W:0]   c_DEPTH_V  = (c_CNT_W + 1)'(DEPTH);

    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [ADDR_W-1:0]  r_inflight_pc;
    logic               r_inflight;
    logic               r_kill;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [31:0]        r_mem_instr [DEPTH];
    logic [ADDR_W-1:0]  r_mem_pc    [DEPTH];
    logic [31:0]        r_hold_instr;
    logic [ADDR_W-1:0]  r_hold_pc;

    logic               w_head_valid;
    logic               w_pop;
    logic               w_push;
    logic [c_CNT_W:0]   w_occ;
    logic               w_unused_bits;

    // Pointers wrap at DEPTH, which may not be a power of two.
    function automatic logic [c_PTR_W-1:0] f_next_ptr(input logic [c_PTR_W-1:0] p);
        return (p == c_LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Handshake, push qualification and issue decision; redirect overrides all.
    assign w_head_valid  = (r_count != '0);
    assign out_valid     = w_head_valid & ~reset;
    assign w_pop         = out_valid & out_ready & ~redirect_valid;
    assign w_push        = r_inflight & ~r_kill & ~redirect_valid & ~reset;
    assign w_occ         = {1'b0, r_count} + {{c_CNT_W{1'b0}}, r_inflight}
                         - {{c_CNT_W{1'b0}}, w_pop};
    assign imem_en       = ~reset & ~redirect_valid & (w_occ < c_DEPTH_V);
    assign imem_addr     = r_fetch_pc[ADDR_W-1:2];
    assign w_unused_bits = ^redirect_pc[1:0];

    // Head presentation: live FIFO head when valid, otherwise last shown value.
    assign out_instr = w_head_valid ? r_mem_instr[r_rd_ptr] : r_hold_instr;
    assign out_pc    = w_head_valid ? r_mem_pc[r_rd_ptr]    : r_hold_pc;
    assign out_link  = out_pc + ADDR_W'(4);

    // Fetch PC, in-flight tracking, kill flag, pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_kill        <= 1'b0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
            r_kill     <= r_inflight;
            r_inflight <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_kill <= 1'b0;
            if (imem_en) begin
                r_fetch_pc    <= r_fetch_pc + ADDR_W'(4);
                r_inflight    <= 1'b1;
                r_inflight_pc <= r_fetch_pc;
            end else begin
                r_inflight    <= 1'b0;
            end
            if (w_push) r_wr_ptr <= f_next_ptr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= f_next_ptr(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage; written only by qualified pushes so needs no reset.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem_instr[r_wr_ptr] <= imem_rdata;
            r_mem_pc[r_wr_ptr]    <= r_inflight_pc;
        end
    end

    // Remember the most recently presented head so outputs hold when empty.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hold_instr <= '0;
            r_hold_pc    <= '0;
        end else if (w_head_valid) begin
            r_hold_instr <= r_mem_instr[r_rd_ptr];
            r_hold_pc    <= r_mem_pc[r_rd_ptr];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_prefetch
// Description : Scoreboard bench for ifetch_prefetch. Stimulus queues the
//               expected in-order PC stream; a monitor checks every pop,
//               issue and valid against a stream-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_prefetch;

    localparam int          c_AW    = 16;
    localparam int          c_DEPTH = 4;
    localparam logic [15:0] c_RPC   = 16'hFFF0;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        imem_en;
    logic [13:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [15:0] out_pc;
    logic [15:0] out_link;

    ifetch_prefetch #(
        .ADDR_W   (c_AW),
        .DEPTH    (c_DEPTH),
        .RESET_PC (c_RPC)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_link       (out_link)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] word_of(input logic [13:0] w);
        return 32'h1000_0000 ^ ({18'd0, w} * 32'h0000_9E37);
    endfunction

    // Synchronous instruction memory: data one cycle after the request.
    always @(posedge clock) begin
        if (imem_en) imem_rdata <= word_of(imem_addr);
    end

    // Scoreboard state
    logic [15:0] exp_q[$];
    logic [15:0] model_next;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Restart the expected PC stream at a new target.
    task automatic flush(input logic [15:0] tgt);
        exp_q.delete();
        model_next = {tgt[15:2], 2'b00};
    endtask

    // Keep the expected stream topped up, then advance one cycle.
    task automatic step();
        while (exp_q.size() < 16) begin
            exp_q.push_back(model_next);
            model_next = model_next + 16'd4;
        end
        @(posedge clock);
        #1;
    endtask

    // Monitor state
    int          k = 0;
    int          issued = 0;
    int          popped = 0;
    logic [15:0] fetch_exp = c_RPC;
    logic [15:0] e_pc;
    bit          pop_now;
    bit          exp_en;

    // Mid-cycle monitor: inputs and outputs are stable here.
    always @(negedge clock) begin
        if (reset) begin
            check("reset_out_valid", {31'd0, out_valid}, 32'd0);
            check("reset_imem_en", {31'd0, imem_en}, 32'd0);
            k = 0; issued = 0; popped = 0;
            fetch_exp = c_RPC;
        end else if (redirect_valid) begin
            check("redirect_imem_en", {31'd0, imem_en}, 32'd0);
            k = 0; issued = 0; popped = 0;
            fetch_exp = {redirect_pc[15:2], 2'b00};
        end else begin
            k++;
            pop_now = out_valid && out_ready;
            exp_en  = (issued - popped - (pop_now ? 1 : 0)) < c_DEPTH;
            check("imem_en", {31'd0, imem_en}, {31'd0, exp_en});
            if (imem_en)
                check("imem_addr", {18'd0, imem_addr}, {18'd0, fetch_exp[15:2]});
            check("out_valid", {31'd0, out_valid}, (k <= 2) ? 32'd0 : 32'd1);
            if (pop_now) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    e_pc = exp_q.pop_front();
                    check("out_pc", {16'd0, out_pc}, {16'd0, e_pc});
                    check("out_instr", out_instr, word_of(e_pc[15:2]));
                    check("out_link", {16'd0, out_link}, {16'd0, e_pc + 16'd4});
                end
                popped++;
            end
            if (imem_en) begin
                issued++;
                fetch_exp = fetch_exp + 16'd4;
            end
        end
    end

    initial begin
        logic [15:0] tgt;
        int          r;
        flush(c_RPC);
        repeat (3) step();

        // Streaming from reset, wrapping through 0xFFFC -> 0x0000
        reset = 1'b0; out_ready = 1'b1;
        repeat (12) step();

        // Back-pressure until the queue fills, then resume
        out_ready = 1'b0;
        repeat (10) step();
        out_ready = 1'b1;
        repeat (6) step();

        // Fill partially then redirect to an unaligned target
        out_ready = 1'b0;
        repeat (4) step();
        redirect_valid = 1'b1; redirect_pc = 16'h0043; flush(16'h0043);
        step();
        redirect_valid = 1'b0; out_ready = 1'b1;
        repeat (6) step();

        // Redirect while popping and pushing, then back-to-back redirects
        redirect_valid = 1'b1; redirect_pc = 16'h1000; flush(16'h1000);
        step();
        redirect_pc = 16'h2006; flush(16'h2006);
        step();
        redirect_valid = 1'b0;
        repeat (6) step();

        // One-cycle reset with entries queued
        out_ready = 1'b0;
        repeat (4) step();
        reset = 1'b1; flush(c_RPC);
        step();
        reset = 1'b0; out_ready = 1'b1;
        repeat (8) step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            out_ready = ($urandom_range(0, 3) != 0);
            reset = 1'b0;
            redirect_valid = 1'b0;
            redirect_pc = 16'($urandom);
            if (r < 2) begin
                reset = 1'b1;
                flush(c_RPC);
            end else if (r < 9) begin
                tgt = ($urandom_range(0, 1) == 0) ? (16'hFFF0 + 16'($urandom_range(0, 15)))
                                                  : 16'($urandom);
                redirect_valid = 1'b1;
                redirect_pc = tgt;
                flush(tgt);
            end
            step();
        end

        reset = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
        repeat (5) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
